// File: rtl/squares_pkg.sv
// -----------------------------------------------------------------------------
// squares_pkg
//   Grid geometry, pixel width and FSM state type shared by the square painter,
//   the framebuffer and the display stages.
//
//   GRID_W  : grid columns (power of two)
//   GRID_H  : grid rows
//   PIXEL_W : pixel width in bits, RGB 8:8:8
//   state_t : painter FSM states
// -----------------------------------------------------------------------------
package squares_pkg;

    localparam int unsigned GRID_W  = 32;
    localparam int unsigned GRID_H  = 16;
    localparam int unsigned PIXEL_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/square_painter.sv
// -----------------------------------------------------------------------------
// square_painter
//   Fills axis-aligned squares of a single colour into a GRID_W x GRID_H
//   framebuffer, one pixel write per clock, and can zero the whole grid.
//   A full clear runs automatically after reset.
//
// Parameters
//   A       : framebuffer address width
//   S       : pixel width (RGB 8:8:8)
//   GRID_W  : grid columns, power of two
//   GRID_H  : grid rows (GRID_W*GRID_H <= 512)
//
// Ports
//   clock, reset_n          : clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready   : draw-command handshake
//   cmd_x, cmd_y, cmd_size  : top-left cell and side length of the square
//   cmd_color               : fill colour
//   clear_req               : one-cycle request to zero the grid (IDLE only)
//   address_in, data_in,
//   wren                    : framebuffer write port (registered)
//   busy                    : high whenever not IDLE
//   done                    : one-cycle pulse when a draw or clear finishes
// -----------------------------------------------------------------------------
module square_painter #(
    parameter int unsigned A      = 10,
    parameter int unsigned S      = squares_pkg::PIXEL_W,
    parameter int unsigned GRID_W = squares_pkg::GRID_W,
    parameter int unsigned GRID_H = squares_pkg::GRID_H
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [4:0]   cmd_x,
    input  logic [3:0]   cmd_y,
    input  logic [4:0]   cmd_size,
    input  logic [S-1:0] cmd_color,
    input  logic         clear_req,
    output logic [A-1:0] address_in,
    output logic [S-1:0] data_in,
    output logic         wren,
    output logic         busy,
    output logic         done
);
    import squares_pkg::*;

    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned CLR_W = $clog2(CELLS) + 1;

    state_t         state, state_next;
    logic [CLR_W-1:0] clr_cnt, clr_cnt_next;
    logic [5:0]     col, col_next;
    logic [5:0]     row, row_next;
    logic           wren_next;
    logic [A-1:0]   addr_next;
    logic [S-1:0]   data_next;

    // Command fields captured on acceptance
    logic           latch_en;
    logic [4:0]     x_lat;
    logic [3:0]     y_lat;
    logic [4:0]     size_lat;
    logic [S-1:0]   color_lat;

    logic [5:0]     x_sum, y_sum, x_end, y_end;
    logic           empty;
    logic           accept;
    logic           cmd_empty;

    function automatic logic [A-1:0] cell_addr(input logic [5:0] r, input logic [5:0] c);
        return A'(32'(r) * GRID_W + 32'(c));
    endfunction

    assign cmd_ready = (state == IDLE) && !clear_req;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign accept    = cmd_valid && cmd_ready;

    // Square extent, one bit wider than the operands so x+size-1 cannot wrap,
    // then clipped to the last column/row of the grid.
    assign x_sum = {1'b0, x_lat} + {1'b0, size_lat} - 6'd1;
    assign y_sum = {2'b00, y_lat} + {1'b0, size_lat} - 6'd1;
    assign x_end = (32'(x_sum) > GRID_W - 1) ? 6'(GRID_W - 1) : x_sum;
    assign y_end = (32'(y_sum) > GRID_H - 1) ? 6'(GRID_H - 1) : y_sum;

    assign empty     = (size_lat == 5'd0) || (32'(x_lat) >= GRID_W) || (32'(y_lat) >= GRID_H);
    assign cmd_empty = (cmd_size == 5'd0) || (32'(cmd_x) >= GRID_W) || (32'(cmd_y) >= GRID_H);

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        col_next     = col;
        row_next     = row;
        wren_next    = 1'b0;
        addr_next    = address_in;
        data_next    = data_in;
        latch_en     = 1'b0;

        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end else if (accept) begin
                    // The first pixel is emitted straight from the command
                    // inputs so the write lands the cycle after acceptance.
                    state_next = DRAW;
                    latch_en   = 1'b1;
                    col_next   = {1'b0, cmd_x};
                    row_next   = {2'b00, cmd_y};
                    if (!cmd_empty) begin
                        wren_next = 1'b1;
                        addr_next = cell_addr({2'b00, cmd_y}, {1'b0, cmd_x});
                        data_next = cmd_color;
                    end
                end
            end

            CLEAR: begin
                if (32'(clr_cnt) == CELLS) begin
                    state_next = DONE;
                end else begin
                    wren_next    = 1'b1;
                    addr_next    = A'(clr_cnt);
                    data_next    = '0;
                    clr_cnt_next = clr_cnt + 1'b1;
                end
            end

            DRAW: begin
                // col/row hold the pixel written last cycle
                if (empty || (col == x_end && row == y_end)) begin
                    state_next = DONE;
                end else begin
                    if (col == x_end) begin
                        col_next = {1'b0, x_lat};
                        row_next = row + 6'd1;
                    end else begin
                        col_next = col + 6'd1;
                    end
                    wren_next = 1'b1;
                    addr_next = cell_addr(row_next, col_next);
                    data_next = color_lat;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            col        <= '0;
            row        <= '0;
            wren       <= 1'b0;
            address_in <= '0;
            data_in    <= '0;
        end else begin
            state      <= state_next;
            clr_cnt    <= clr_cnt_next;
            col        <= col_next;
            row        <= row_next;
            wren       <= wren_next;
            address_in <= addr_next;
            data_in    <= data_next;
        end
    end

    // Command capture carries no control meaning, so it is left unreset
    always_ff @(posedge clock) begin
        if (latch_en) begin
            x_lat     <= cmd_x;
            y_lat     <= cmd_y;
            size_lat  <= cmd_size;
            color_lat <= cmd_color;
        end
    end

endmodule

// File: tb/tb_square_painter.sv
module tb_square_painter;

    localparam int A = 10;
    localparam int S = 24;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd_x;
    logic [3:0]   cmd_y;
    logic [4:0]   cmd_size;
    logic [S-1:0] cmd_color;
    logic         clear_req;
    logic [A-1:0] address_in;
    logic [S-1:0] data_in;
    logic         wren;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    logic [A-1:0] wa_q[$];
    logic [S-1:0] wd_q[$];
    int           done_cnt = 0;

    always #5 clock = ~clock;

    square_painter #(.A(A), .S(S), .GRID_W(32), .GRID_H(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_size   (cmd_size),
        .cmd_color  (cmd_color),
        .clear_req  (clear_req),
        .address_in (address_in),
        .data_in    (data_in),
        .wren       (wren),
        .busy       (busy),
        .done       (done)
    );

    // Write/done monitor, sampled on the inactive edge
    always @(negedge clock) begin
        if (wren === 1'b1) begin
            wa_q.push_back(address_in);
            wd_q.push_back(data_in);
        end
        if (done === 1'b1) done_cnt++;
    end

    // Issue one command; k = negedges after acceptance until done (40 = timeout)
    task automatic run_cmd(input logic [4:0] x, input logic [3:0] y, input logic [4:0] s,
                           input logic [S-1:0] c, output int k);
        @(negedge clock);
        wa_q.delete();
        wd_q.delete();
        cmd_x = x; cmd_y = y; cmd_size = s; cmd_color = c; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_x = 5'h11; cmd_y = 4'h5; cmd_size = 5'h1F; cmd_color = 24'hABCDEF;
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic test_reset();
        int k, bad, first;
        reset_n = 1'b0; cmd_valid = 1'b0; clear_req = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_size = '0; cmd_color = '0;
        repeat (2) @(negedge clock);
        vectors++; if (wren !== 1'b0) begin miscompares++; $display("FAIL reset_wren: got %b want 0", wren); end
        vectors++; if (address_in !== '0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", address_in); end
        vectors++; if (data_in !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", data_in); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
        wa_q.delete(); wd_q.delete();
        done_cnt = 0;
        reset_n = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 700) begin
            @(negedge clock);
            k++;
        end
        vectors++; if (k >= 700) begin miscompares++; $display("FAIL autoclear_done: no done within %0d cycles, required a done pulse", k); end
        vectors++; if (wa_q.size() !== 512) begin miscompares++; $display("FAIL autoclear_count: got %0d writes want 512", wa_q.size()); end
        bad = 0; first = -1;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== A'(i) || wd_q[i] !== '0) begin bad++; if (first < 0) first = i; end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL autoclear_content: %0d bad writes, first idx %0d addr %0d data %h, want addr=idx data=0",
                     bad, first, wa_q[first], wd_q[first]);
        end
        @(negedge clock);
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL autoclear_pulses: got %0d done pulses want 1", done_cnt); end
        vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL autoclear_idle: ready=%b busy=%b want 1/0", cmd_ready, busy); end
    endtask

    task automatic test_draw_basic();
        int k;
        logic [A-1:0] exp_a[4] = '{10'd98, 10'd99, 10'd130, 10'd131};
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready: got %b want 1", cmd_ready); end
        run_cmd(5'd2, 4'd3, 5'd2, 24'hFF0000, k);
        vectors++; if (k !== 5) begin miscompares++; $display("FAIL basic_done_lat: got %0d want 5", k); end
        vectors++; if (wa_q.size() !== 4) begin miscompares++; $display("FAIL basic_count: got %0d want 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            vectors++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== 24'hFF0000) begin
                miscompares++;
                $display("FAIL basic_write%0d: got addr %0d data %h want addr %0d data ff0000", i, wa_q[i], wd_q[i], exp_a[i]);
            end
        end
        @(negedge clock);
        vectors++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL basic_after: done=%b busy=%b ready=%b want 0/0/1", done, busy, cmd_ready);
        end
    endtask

    task automatic test_clip_corner();
        int k;
        logic [A-1:0] exp_a[4] = '{10'd478, 10'd479, 10'd510, 10'd511};
        run_cmd(5'd30, 4'd14, 5'd5, 24'h00FF00, k);
        vectors++; if (k !== 5) begin miscompares++; $display("FAIL clip_done_lat: got %0d want 5", k); end
        vectors++; if (wa_q.size() !== 4) begin miscompares++; $display("FAIL clip_count: got %0d want 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            vectors++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== 24'h00FF00) begin
                miscompares++;
                $display("FAIL clip_write%0d: got addr %0d data %h want addr %0d data 00ff00", i, wa_q[i], wd_q[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_size_zero();
        int k;
        run_cmd(5'd4, 4'd4, 5'd0, 24'h0000FF, k);
        vectors++; if (k !== 2) begin miscompares++; $display("FAIL zero_done_lat: got %0d want 2", k); end
        vectors++; if (wa_q.size() !== 0) begin miscompares++; $display("FAIL zero_writes: got %0d want 0", wa_q.size()); end
    endtask

    task automatic test_clip_bottom();
        int k;
        logic [A-1:0] exp_a[3] = '{10'd483, 10'd484, 10'd485};
        run_cmd(5'd3, 4'd15, 5'd3, 24'h808080, k);
        vectors++; if (k !== 4) begin miscompares++; $display("FAIL bottom_done_lat: got %0d want 4", k); end
        vectors++; if (wa_q.size() !== 3) begin miscompares++; $display("FAIL bottom_count: got %0d want 3", wa_q.size()); end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            vectors++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== 24'h808080) begin
                miscompares++;
                $display("FAIL bottom_write%0d: got addr %0d data %h want addr %0d data 808080", i, wa_q[i], wd_q[i], exp_a[i]);
            end
        end
    endtask

    // clear_req and a new command during a draw must both be ignored
    task automatic test_ignore_while_busy();
        int k;
        logic [A-1:0] exp_a[9] = '{10'd0, 10'd1, 10'd2, 10'd32, 10'd33, 10'd34, 10'd64, 10'd65, 10'd66};
        @(negedge clock);
        wa_q.delete(); wd_q.delete();
        cmd_x = 5'd0; cmd_y = 4'd0; cmd_size = 5'd3; cmd_color = 24'h0000FF; cmd_valid = 1'b1;
        @(negedge clock);
        k = 1;
        clear_req = 1'b1; cmd_x = 5'd20; cmd_y = 4'd9; cmd_size = 5'd7; cmd_color = 24'h112233;
        #1;
        vectors++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL busy_flags: ready=%b busy=%b want 0/1", cmd_ready, busy); end
        @(negedge clock);
        k++;
        clear_req = 1'b0; cmd_valid = 1'b0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        vectors++; if (k !== 10) begin miscompares++; $display("FAIL busy_done_lat: got %0d want 10", k); end
        vectors++; if (wa_q.size() !== 9) begin miscompares++; $display("FAIL busy_count: got %0d want 9", wa_q.size()); end
        for (int i = 0; i < 9 && i < wa_q.size(); i++) begin
            vectors++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== 24'h0000FF) begin
                miscompares++;
                $display("FAIL busy_write%0d: got addr %0d data %h want addr %0d data 0000ff", i, wa_q[i], wd_q[i], exp_a[i]);
            end
        end
        @(negedge clock);
        vectors++; if (busy !== 1'b0 || wren !== 1'b0) begin miscompares++; $display("FAIL busy_after: busy=%b wren=%b want 0/0", busy, wren); end
    endtask

    task automatic test_clear_wins();
        int k, bad, first, rdy_bad;
        @(negedge clock);
        wa_q.delete(); wd_q.delete();
        clear_req = 1'b1; cmd_valid = 1'b1;
        cmd_x = 5'd0; cmd_y = 4'd0; cmd_size = 5'd1; cmd_color = 24'h123456;
        #1;
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL clrwin_ready: got %b want 0", cmd_ready); end
        @(negedge clock);
        clear_req = 1'b0; cmd_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clrwin_busy: got %b want 1", busy); end
        k = 1; rdy_bad = 0;
        while (done !== 1'b1 && k < 700) begin
            if (cmd_ready !== 1'b0) rdy_bad++;
            @(negedge clock);
            k++;
        end
        vectors++; if (k >= 700) begin miscompares++; $display("FAIL clrwin_done: no done within %0d cycles", k); end
        vectors++; if (rdy_bad !== 0) begin miscompares++; $display("FAIL clrwin_ready_held: ready high in %0d cycles want 0", rdy_bad); end
        vectors++; if (wa_q.size() !== 512) begin miscompares++; $display("FAIL clrwin_count: got %0d writes want 512", wa_q.size()); end
        bad = 0; first = -1;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== A'(i) || wd_q[i] !== '0) begin bad++; if (first < 0) first = i; end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL clrwin_content: %0d bad writes, first idx %0d addr %0d data %h, want addr=idx data=0",
                     bad, first, wa_q[first], wd_q[first]);
        end
        @(negedge clock);
        vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || wren !== 1'b0) begin
            miscompares++; $display("FAIL clrwin_after: ready=%b busy=%b wren=%b want 1/0/0", cmd_ready, busy, wren);
        end
    endtask

    task automatic test_reset_mid_draw();
        int k, bad, first, dc;
        @(negedge clock);
        wa_q.delete(); wd_q.delete();
        cmd_x = 5'd0; cmd_y = 4'd0; cmd_size = 5'd4; cmd_color = 24'hC0FFEE; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        vectors++; if (wren !== 1'b1 || address_in !== 10'd2) begin
            miscompares++; $display("FAIL rstmid_third: wren=%b addr %0d want 1/2", wren, address_in);
        end
        dc = done_cnt;
        reset_n = 1'b0;
        #1;
        vectors++; if (wren !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_abort: wren=%b busy=%b done=%b ready=%b want 0/1/0/0", wren, busy, done, cmd_ready);
        end
        @(negedge clock);
        wa_q.delete(); wd_q.delete();
        reset_n = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 700) begin
            @(negedge clock);
            k++;
        end
        vectors++; if (k >= 700) begin miscompares++; $display("FAIL rstmid_done: no done within %0d cycles", k); end
        vectors++; if (wa_q.size() !== 512) begin miscompares++; $display("FAIL rstmid_count: got %0d writes want 512", wa_q.size()); end
        bad = 0; first = -1;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== A'(i) || wd_q[i] !== '0) begin bad++; if (first < 0) first = i; end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL rstmid_content: %0d bad writes, first idx %0d addr %0d data %h, want addr=idx data=0",
                     bad, first, wa_q[first], wd_q[first]);
        end
        @(negedge clock);
        vectors++; if (done_cnt - dc !== 1) begin miscompares++; $display("FAIL rstmid_pulses: got %0d done pulses want 1", done_cnt - dc); end
    endtask

    initial begin
        test_reset();
        test_draw_basic();
        test_clip_corner();
        test_size_zero();
        test_clip_bottom();
        test_ignore_while_busy();
        test_clear_wins();
        test_reset_mid_draw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
